// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush/redirect sequencing for a 5-stage RV32I pipeline with a saturating stall counter.
module pipeline_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic [31:0]      ex_target,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             stall_id_ex,
  output logic             stall_ex_mem,
  output logic             bubble_id_ex,
  output logic             bubble_mem_wb,
  output logic             flush_if_id,
  output logic             pc_redirect,
  output logic [31:0]      pc_target,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {RUN = 2'd0, IMEM_WAIT = 2'd1, DMEM_WAIT = 2'd2} state_t;
  state_t            state_q, state_d;
  logic              pend_valid_q, pend_valid_d;
  logic [31:0]       pend_target_q, pend_target_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              load_use, dwait, iwait;
  logic              s_pc, s_ifid, s_idex, s_exmem, b_idex, b_memwb, f_ifid, redir;
  logic [31:0]       tgt;
  assign load_use = ex_mem_read & (ex_rd != 5'd0) &
                    ((id_use_rs1 & (ex_rd == id_rs1)) | (id_use_rs2 & (ex_rd == id_rs2)));
  assign dwait = dmem_req & ~dmem_ready;
  assign iwait = ~imem_ready;
  // EX frozen by a data wait re-presents its redirect/hazard later, so dwait masks everything.
  always_comb begin
    s_pc = 1'b0;
    s_ifid = 1'b0;
    s_idex = 1'b0;
    s_exmem = 1'b0;
    b_idex = 1'b0;
    b_memwb = 1'b0;
    f_ifid = 1'b0;
    redir = 1'b0;
    tgt = 32'd0;
    state_d = RUN;
    pend_valid_d = pend_valid_q;
    pend_target_d = pend_target_q;
    if (dwait) begin
      s_pc = 1'b1;
      s_ifid = 1'b1;
      s_idex = 1'b1;
      s_exmem = 1'b1;
      b_memwb = 1'b1;
      state_d = DMEM_WAIT;
    end else if (ex_redirect) begin
      b_idex = 1'b1;
      f_ifid = 1'b1;
      if (imem_ready) begin
        redir = 1'b1;
        tgt = ex_target;
        pend_valid_d = 1'b0;
      end else begin
        s_pc = 1'b1;
        pend_valid_d = 1'b1;
        pend_target_d = ex_target;
        state_d = IMEM_WAIT;
      end
    end else if (pend_valid_q && imem_ready) begin
      redir = 1'b1;
      tgt = pend_target_q;
      f_ifid = 1'b1;
      pend_valid_d = 1'b0;
    end else if (load_use) begin
      s_pc = 1'b1;
      s_ifid = 1'b1;
      b_idex = 1'b1;
      state_d = iwait ? IMEM_WAIT : RUN;
    end else if (iwait) begin
      s_pc = 1'b1;
      f_ifid = 1'b1;
      state_d = IMEM_WAIT;
    end
    stall_cnt_d = (s_pc && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pend_valid_q <= 1'b0;
      pend_target_q <= 32'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_target_q <= pend_target_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign stall_pc = s_pc & ~rst;
  assign stall_if_id = s_ifid & ~rst;
  assign stall_id_ex = s_idex & ~rst;
  assign stall_ex_mem = s_exmem & ~rst;
  assign bubble_id_ex = b_idex & ~rst;
  assign bubble_mem_wb = b_memwb & ~rst;
  assign flush_if_id = f_ifid & ~rst;
  assign pc_redirect = redir & ~rst;
  assign pc_target = rst ? 32'd0 : tgt;
  assign state = state_q;
  assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed vectors with hand-computed control patterns for pipeline_ctrl.
module tb_pipeline_ctrl;
  localparam int CW = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect, imem_ready, dmem_req, dmem_ready;
  logic [31:0] ex_target, pc_target;
  logic stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, bubble_id_ex, bubble_mem_wb, flush_if_id, pc_redirect;
  logic [1:0] state;
  logic [CW-1:0] stall_cnt;
  logic [7:0] ctrl;
  int checks = 0, errors = 0;
  pipeline_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
    .ex_target(ex_target), .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
    .stall_ex_mem(stall_ex_mem), .bubble_id_ex(bubble_id_ex), .bubble_mem_wb(bubble_mem_wb),
    .flush_if_id(flush_if_id), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .state(state), .stall_cnt(stall_cnt)
  );
  // {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, bubble_id_ex, bubble_mem_wb, flush_if_id, pc_redirect}
  assign ctrl = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, bubble_id_ex, bubble_mem_wb, flush_if_id, pc_redirect};
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; ex_rd = 0; ex_mem_read = 0;
    ex_redirect = 0; ex_target = 0; imem_ready = 1; dmem_req = 0; dmem_ready = 0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_ctl(input string tag, input logic [7:0] ec, input logic [31:0] et);
    chk({tag, "_ctrl"}, {24'd0, ctrl}, {24'd0, ec});
    chk({tag, "_tgt"}, pc_target, et);
  endtask
  initial begin
    idle();
    ex_redirect = 1; ex_target = 32'h700; imem_ready = 0;
    #2;
    chk_ctl("reset", 8'h00, 0);
    chk("reset_state", {30'd0, state}, 0);
    chk("reset_cnt", {28'd0, stall_cnt}, 0);
    tick();
    rst = 0;
    idle();
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    #1;
    chk_ctl("lu_rs1", 8'b1100_1000, 0);
    tick();
    idle();
    #1;
    chk_ctl("lu_after", 8'h00, 0);
    chk("lu_cnt", {28'd0, stall_cnt}, 1);
    ex_mem_read = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1; id_rs1 = 3; id_use_rs1 = 1;
    #1;
    chk_ctl("lu_rs2", 8'b1100_1000, 0);
    tick();
    idle();
    ex_mem_read = 1; ex_rd = 9; id_rs1 = 9; id_use_rs1 = 0;
    #1;
    chk_ctl("lu_unused", 8'h00, 0);
    ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
    #1;
    chk_ctl("lu_x0", 8'h00, 0);
    tick();
    chk("cnt2", {28'd0, stall_cnt}, 2);
    idle();
    ex_redirect = 1; ex_target = 32'h100;
    ex_mem_read = 1; ex_rd = 4; id_rs1 = 4; id_use_rs1 = 1;
    #1;
    chk_ctl("branch", 8'b0000_1011, 32'h100);
    tick();
    idle();
    imem_ready = 0; ex_redirect = 1; ex_target = 32'h200;
    #1;
    chk_ctl("iw_redir", 8'b1000_1010, 0);
    tick();
    chk("iw_state", {30'd0, state}, 1);
    idle(); imem_ready = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk_ctl("iw_hold", 8'b1000_0010, 0);
      tick();
    end
    idle();
    #1;
    chk_ctl("iw_release", 8'b0000_0011, 32'h200);
    tick();
    chk("iw_run", {30'd0, state}, 0);
    chk("cnt5", {28'd0, stall_cnt}, 5);
    imem_ready = 0; ex_redirect = 1; ex_target = 32'h300;
    tick();
    ex_target = 32'h400;
    tick();
    idle();
    #1;
    chk_ctl("overwrite", 8'b0000_0011, 32'h400);
    tick();
    dmem_req = 1; ex_redirect = 1; ex_target = 32'h500;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk_ctl("dwait", 8'b1111_0100, 0);
      tick();
      chk("dw_state", {30'd0, state}, 2);
    end
    dmem_ready = 1;
    #1;
    chk_ctl("dw_release", 8'b0000_1011, 32'h500);
    tick();
    chk("dw_run", {30'd0, state}, 0);
    chk("cnt9", {28'd0, stall_cnt}, 9);
    idle();
    imem_ready = 0; ex_mem_read = 1; ex_rd = 6; id_rs1 = 6; id_use_rs1 = 1;
    #1;
    chk_ctl("lu_iwait", 8'b1100_1000, 0);
    tick();
    idle();
    #1;
    chk_ctl("lu_iwait_after", 8'h00, 0);
    tick();
    imem_ready = 0;
    #1;
    chk_ctl("iwait", 8'b1000_0010, 0);
    tick();
    chk("iwait_state", {30'd0, state}, 1);
    ex_redirect = 1; ex_target = 32'h600;
    tick();
    chk("cnt12", {28'd0, stall_cnt}, 12);
    idle(); imem_ready = 0;
    rst = 1;
    #1;
    chk_ctl("midrst", 8'h00, 0);
    chk("midrst_state", {30'd0, state}, 0);
    chk("midrst_cnt", {28'd0, stall_cnt}, 0);
    tick();
    rst = 0; imem_ready = 1;
    #1;
    chk_ctl("post_rst", 8'h00, 0);
    tick();
    imem_ready = 0;
    for (int i = 0; i < 17; i++) tick();
    chk("sat_cnt", {28'd0, stall_cnt}, 15);
    chk("sat_state", {30'd0, state}, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage RV32I pipeline. It generates the per-stage stall and flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers from four event sources: load-use hazards, taken branches and jumps resolved in EX, instruction-memory wait, and data-memory wait. It holds a branch redirect that arrives during an instruction-fetch wait until the fetch completes. It also keeps a stall-cycle performance counter.

Parameters:
CNT_W, 32, width of the stall-cycle counter (saturating)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
id_rs1  in  5  rs1 index of the instruction in ID
id_rs2  in  5  rs2 index of the instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  destination register of the instruction in EX
ex_mem_read  in  1  instruction in EX is a load
ex_redirect  in  1  EX resolved a taken branch or jump this cycle
ex_target  in  32  redirect target address
imem_ready  in  1  fetch data valid this cycle
dmem_req  in  1  MEM stage is accessing data memory
dmem_ready  in  1  data memory access completes this cycle
stall_pc  out  1  hold PC
stall_if_id  out  1  hold IF/ID
stall_id_ex  out  1  hold ID/EX
stall_ex_mem  out  1  hold EX/MEM
bubble_id_ex  out  1  load a NOP into ID/EX
bubble_mem_wb  out  1  load a NOP into MEM/WB
flush_if_id  out  1  IF/ID flush bit input (marks the fetched instruction as killed)
pc_redirect  out  1  PC takes pc_target
pc_target  out  32  redirect address
state  out  2  FSM state: 0 RUN, 1 IMEM_WAIT, 2 DMEM_WAIT
stall_cnt  out  CNT_W  cycles with stall_pc=1, saturating

Behaviour:
- Reset (asynchronous, rst=1): state=RUN, pending_valid=0, pending_target=0, stall_cnt=0. All control outputs are 0 and pc_target=0 while reset is asserted. Reset mid-wait abandons the pending redirect.
- Definitions:
  - load_use = ex_mem_read & (ex_rd!=0) & ((id_use_rs1 & ex_rd==id_rs1) | (id_use_rs2 & ex_rd==id_rs2)).
  - dwait = dmem_req & ~dmem_ready.
  - iwait = ~imem_ready.
- Output priority (combinational from state, registers and inputs; highest first):
  1. dwait: stall_pc, stall_if_id, stall_id_ex and stall_ex_mem =1; bubble_mem_wb=1. ex_redirect and load_use are ignored this cycle, because EX is frozen and re-presents them. Next state = DMEM_WAIT.
  2. ex_redirect (no dwait): bubble_id_ex=1, flush_if_id=1.
     - If imem_ready: pc_redirect=1, pc_target=ex_target.
     - Else: latch pending_valid=1 and pending_target=ex_target; stall_pc=1; next state = IMEM_WAIT.
     - Redirect overrides load_use (the ID instruction is squashed).
  3. load_use: stall_pc=1, stall_if_id=1, bubble_id_ex=1 for exactly one cycle. An iwait in the same cycle adds no extra controls.
  4. iwait: stall_pc=1; flush_if_id=1 (IF/ID captures a killed slot, no stall of downstream stages); next state = IMEM_WAIT.
- IMEM_WAIT:
  - Leave on imem_ready.
  - If pending_valid on that cycle: pc_redirect=1, pc_target=pending_target, flush_if_id=1, clear pending_valid. This kills the stale fetched word.
  - A new ex_redirect while pending_valid=1 overwrites pending_target.
- DMEM_WAIT: return to RUN on the cycle dmem_ready=1. That cycle releases all stalls and bubble_mem_wb=0.
- stall_cnt: +1 on every cycle with stall_pc=1; holds at all-ones.
- pc_target = 0 whenever pc_redirect=0.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> one cycle of stall_pc=stall_if_id=bubble_id_ex=1; all 0 the next cycle; stall_cnt=1.
- x0 no hazard: ex_rd=0, id_rs1=0, ex_mem_read=1 -> no stall, no bubble.
- Taken branch: ex_redirect=1, ex_target=0x0000_0100, imem_ready=1 -> pc_redirect=1, pc_target=0x100, flush_if_id=1, bubble_id_ex=1 in the same cycle.
- Redirect during fetch wait: imem_ready=0 for 3 cycles, ex_redirect=1 with ex_target=0x200 in the first cycle -> state=IMEM_WAIT, stall_pc=1 for 3 cycles, then on imem_ready=1 pc_redirect=1, pc_target=0x200, flush_if_id=1; state returns to RUN.
- Data wait overrides: dmem_req=1, dmem_ready=0 for 2 cycles with ex_redirect=1 -> all four stalls and bubble_mem_wb=1 for 2 cycles, no pc_redirect; redirect fires on the release cycle.
- Reset mid-IMEM_WAIT with pending_valid=1 -> all outputs 0, state=RUN, stall_cnt=0; no redirect after reset release.
